// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
package burst_mem_pkg;

    // Transaction sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LAT   = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BURST_W     = 64;
    localparam int LINE_W      = 256;
    localparam int BURST_LEN   = 4;
    localparam int OFFSET_BITS = 5;

endpackage

// File: rtl/burst_mem_array.sv
// Line-organised storage: combinational read of a full line, synchronous full-line write.
module burst_mem_array
    import burst_mem_pkg::*;
#(
    parameter int LINE_IDX_W = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [LINE_IDX_W-1:0] idx,
    input  logic [LINE_W-1:0]     wdata,
    input  logic [LINE_IDX_W-1:0] rd_idx,
    output logic [LINE_W-1:0]     rdata
);

    logic [LINE_W-1:0] mem [2**LINE_IDX_W];

    // Full-line commit; contents are deliberately never cleared
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[rd_idx];

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat, 64-bit burst protocol.
// Accepts one read or write at a time, waits LATENCY cycles, then streams
// four beats. Writes are assembled in a line buffer and committed whole.
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int LATENCY    = 4,   // legal range 1..15
    parameter int LINE_IDX_W = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                read_i,
    input  logic                write_i,
    input  logic [31:0]         address_i,
    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    output logic                resp_o,
    output logic                err_o
);

    // Last latency-count value before the first beat (LAT lasts LATENCY-1 cycles)
    localparam logic [3:0] LAT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t                  state_reg, state_next;
    logic [1:0]              beat_reg, beat_next;
    logic [3:0]              lat_reg, lat_next;
    logic                    write_reg, write_next;
    logic [LINE_IDX_W-1:0]   idx_reg, idx_next;
    logic [LINE_W-1:0]       line_buf_reg, line_buf_next;
    logic                    err_reg, err_next;

    logic                    req;
    logic                    mem_we;
    logic [LINE_IDX_W-1:0]   req_idx;
    logic [LINE_W-1:0]       rd_line;
    logic [LINE_W-1:0]       commit_line;
    logic [BURST_W-1:0]      buf_beats [BURST_LEN];
    logic                    unused_addr_bits;

    assign req     = read_i | write_i;
    assign req_idx = address_i[OFFSET_BITS +: LINE_IDX_W];

    // Offset and aliased high address bits are intentionally ignored
    assign unused_addr_bits = ^{address_i[31:OFFSET_BITS+LINE_IDX_W], address_i[OFFSET_BITS-1:0]};

    // Beat view of the line buffer; the committed line takes beat 3 straight
    // from burst_i so the whole line lands in the array at the beat-3 edge.
    genvar gi;
    generate
        for (gi = 0; gi < BURST_LEN; gi++) begin : g_beat
            assign buf_beats[gi] = line_buf_reg[gi*BURST_W +: BURST_W];
            if (gi == BURST_LEN - 1) begin : g_last
                assign commit_line[gi*BURST_W +: BURST_W] = burst_i;
            end else begin : g_prev
                assign commit_line[gi*BURST_W +: BURST_W] = line_buf_reg[gi*BURST_W +: BURST_W];
            end
        end
    endgenerate

    burst_mem_array #(
        .LINE_IDX_W (LINE_IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (mem_we),
        .idx    (idx_reg),
        .wdata  (commit_line),
        .rd_idx (req_idx),
        .rdata  (rd_line)
    );

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            beat_reg     <= '0;
            lat_reg      <= '0;
            write_reg    <= 1'b0;
            idx_reg      <= '0;
            line_buf_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_reg     <= beat_next;
            lat_reg      <= lat_next;
            write_reg    <= write_next;
            idx_reg      <= idx_next;
            line_buf_reg <= line_buf_next;
            err_reg      <= err_next;
        end
    end

    // Next-state logic; dropping both requests in LAT/BURST aborts to IDLE
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next = (LATENCY > 1) ? LAT : BURST;
                end
            end
            LAT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (lat_reg == LAT_LAST) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (beat_reg == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, request latching, line buffer capture and conflict flag
    always_comb begin
        beat_next     = beat_reg;
        lat_next      = lat_reg;
        write_next    = write_reg;
        idx_next      = idx_reg;
        line_buf_next = line_buf_reg;
        err_next      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                beat_next = '0;
                lat_next  = '0;
                if (req) begin
                    // Read wins a conflict; the line is fetched regardless of op
                    write_next    = write_i & ~read_i;
                    idx_next      = req_idx;
                    line_buf_next = rd_line;
                    err_next      = read_i & write_i;
                end
            end
            LAT: begin
                lat_next = lat_reg + 4'd1;
            end
            BURST: begin
                if (write_reg) begin
                    for (int b = 0; b < BURST_LEN; b++) begin
                        if (beat_reg == 2'(b)) begin
                            line_buf_next[b*BURST_W +: BURST_W] = burst_i;
                        end
                    end
                end
                beat_next = beat_reg + 2'd1;
            end
            DONE: begin
                beat_next = beat_reg;
            end
            default: begin
                beat_next = '0;
            end
        endcase
        // An abort leaves the counters clean for the next request
        if (state_reg != IDLE && state_next == IDLE) begin
            beat_next = '0;
            lat_next  = '0;
        end
    end

    // Beat strobe, read data and array commit are decoded from the current state
    always_comb begin
        resp_o  = 1'b0;
        burst_o = '0;
        mem_we  = 1'b0;
        if (state_reg == BURST) begin
            resp_o = 1'b1;
            if (!write_reg) begin
                burst_o = buf_beats[beat_reg];
            end
            // No commit on abort or while reset is asserted
            mem_we = write_reg && (beat_reg == 2'd3) && req && reset_n;
        end
    end

    assign err_o = err_reg;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Randomized self-checking bench: three responders (LATENCY 4, 1, 15) share
// stimulus lines, one is selected per transaction, and every cycle of every
// transaction is compared against a line-level memory model.
module tb_burst_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        read_drv, write_drv;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          sel;

    logic [2:0]  rd_v, wr_v, resp_v, err_v;
    logic [63:0] bo0, bo1, bo2;

    logic [255:0] mem_m [3][32];

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    // Route the request to the selected responder only
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd_v[i] = read_drv  && (sel == i);
            wr_v[i] = write_drv && (sel == i);
        end
    end

    burst_mem_responder #(.LATENCY(4), .LINE_IDX_W(5)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .read_i(rd_v[0]), .write_i(wr_v[0]),
        .address_i(addr), .burst_i(wdata), .burst_o(bo0), .resp_o(resp_v[0]), .err_o(err_v[0]));

    burst_mem_responder #(.LATENCY(1), .LINE_IDX_W(5)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .read_i(rd_v[1]), .write_i(wr_v[1]),
        .address_i(addr), .burst_i(wdata), .burst_o(bo1), .resp_o(resp_v[1]), .err_o(err_v[1]));

    burst_mem_responder #(.LATENCY(15), .LINE_IDX_W(5)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .read_i(rd_v[2]), .write_i(wr_v[2]),
        .address_i(addr), .burst_i(wdata), .burst_o(bo2), .resp_o(resp_v[2]), .err_o(err_v[2]));

    function automatic int lat_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    function automatic logic [63:0] bo_of(input int d);
        case (d)
            0:       return bo0;
            1:       return bo1;
            default: return bo2;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand256();
        return {rand64(), rand64(), rand64(), rand64()};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on responder d. Cycle j is counted from acceptance (j=0 is T).
    // drop_j: cycle in which both requests go low early (-1 none);
    // rst_j: cycle in which reset_n is asserted (-1 none); hold: extra DONE cycles.
    task automatic run_txn(input int d, input bit is_wr, input bit both, input logic [31:0] a,
                           input int drop_j, input int rst_j, input int hold,
                           input logic [255:0] wline);
        int           lat;
        int           line;
        int           j;
        int           k;
        bit           eff_wr;
        bit           exp_resp;
        bit           done;
        logic [255:0] old_line;
        logic [63:0]  exp_bo;

        lat      = lat_of(d);
        line     = int'((a >> 5) % 32);
        eff_wr   = is_wr && !both;
        old_line = mem_m[d][line];

        @(negedge clk);
        sel       = d;
        read_drv  = !is_wr || both;
        write_drv = is_wr || both;
        addr      = a;
        wdata     = rand64();

        j    = 0;
        done = 1'b0;
        while (!done) begin
            j++;
            @(negedge clk);
            exp_resp = (j >= lat) && (j < lat + 4)
                       && (drop_j < 0 || j <= drop_j) && (rst_j < 0 || j <= rst_j);
            k = j - lat;
            exp_bo = 64'd0;
            if (exp_resp && !eff_wr) begin
                exp_bo = old_line[k*64 +: 64];
            end
            check_eq($sformatf("d%0d j%0d resp", d, j), {63'd0, resp_v[d]}, {63'd0, exp_resp});
            check_eq($sformatf("d%0d j%0d err", d, j), {63'd0, err_v[d]}, {63'd0, (j == 1) && both});
            check_eq($sformatf("d%0d j%0d burst_o", d, j), bo_of(d), exp_bo);

            // Address wanders after acceptance; burst_i carries garbage outside beats
            addr  = $urandom;
            wdata = rand64();
            if (eff_wr && exp_resp) begin
                wdata = wline[k*64 +: 64];
            end

            if (rst_j >= 0) begin
                if (j == rst_j) begin
                    reset_n = 1'b0;
                end else if (j == rst_j + 1) begin
                    reset_n   = 1'b1;
                    read_drv  = 1'b0;
                    write_drv = 1'b0;
                    done      = 1'b1;
                end
            end else if (drop_j >= 0) begin
                if (j == drop_j) begin
                    read_drv  = 1'b0;
                    write_drv = 1'b0;
                end else if (j == drop_j + 1) begin
                    done = 1'b1;
                end
            end else begin
                if (j == lat + 4 + hold) begin
                    read_drv  = 1'b0;
                    write_drv = 1'b0;
                end else if (j == lat + 5 + hold) begin
                    done = 1'b1;
                end
            end
        end

        if (eff_wr && drop_j < 0 && rst_j < 0) begin
            mem_m[d][line] = wline;
        end
        $display("txn dut%0d op=%s both=%0d addr=%h line=%0d drop=%0d rst=%0d hold=%0d",
                 d, is_wr ? "WR" : "RD", both, a, line, drop_j, rst_j, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] pat_a;
        int           d, mode, lat, drop_j, rst_j;
        bit           is_wr, both;

        reset_n   = 1'b0;
        read_drv  = 1'b0;
        write_drv = 1'b0;
        addr      = '0;
        wdata     = '0;
        sel       = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst d%0d resp", i), {63'd0, resp_v[i]}, 64'd0);
            check_eq($sformatf("rst d%0d err", i), {63'd0, err_v[i]}, 64'd0);
            check_eq($sformatf("rst d%0d burst_o", i), bo_of(i), 64'd0);
        end
        reset_n = 1'b1;

        // Give every line of every responder known contents
        for (int i = 0; i < 3; i++) begin
            for (int ln = 0; ln < 32; ln++) begin
                run_txn(i, 1'b1, 1'b0, 32'(ln) << 5, -1, -1, 0, rand256());
            end
        end

        // Write then read with recognizable beat patterns
        pat_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        run_txn(0, 1'b1, 1'b0, 32'h0000_0040, -1, -1, 2, pat_a);
        run_txn(0, 1'b0, 1'b0, 32'h0000_0040, -1, -1, 0, '0);

        // Latency sweep, with DONE held for a while
        for (int i = 1; i < 3; i++) begin
            run_txn(i, 1'b1, 1'b0, 32'h0000_0040, -1, -1, 6, pat_a);
            run_txn(i, 1'b0, 1'b0, 32'h0000_0040, -1, -1, 20, '0);
        end

        // Offset bits and high address bits alias to the same line
        run_txn(0, 1'b1, 1'b0, 32'h0000_0020, -1, -1, 0, rand256());
        run_txn(0, 1'b0, 1'b0, 32'h0000_003F, -1, -1, 0, '0);
        run_txn(0, 1'b0, 1'b0, 32'h8000_0020, -1, -1, 0, '0);

        // Abort a write to line 3 after two beats, then confirm old contents
        run_txn(0, 1'b1, 1'b0, 32'h0000_0060, lat_of(0) + 2, -1, 0, rand256());
        run_txn(0, 1'b0, 1'b0, 32'h0000_0060, -1, -1, 0, '0);

        // Conflicting request: read proceeds, err pulses, array untouched
        run_txn(0, 1'b1, 1'b1, 32'h0000_0060, -1, -1, 1, rand256());
        run_txn(0, 1'b0, 1'b0, 32'h0000_0060, -1, -1, 0, '0);

        // Reset during beat 2 of a write, then a clean read
        run_txn(0, 1'b1, 1'b0, 32'h0000_0040, -1, lat_of(0) + 2, 0, rand256());
        run_txn(0, 1'b0, 1'b0, 32'h0000_0040, -1, -1, 0, '0);

        // Randomized traffic across all responders
        for (int n = 0; n < 200; n++) begin
            d      = int'($urandom_range(0, 2));
            lat    = lat_of(d);
            is_wr  = 1'($urandom_range(0, 1));
            both   = ($urandom_range(0, 9) == 0);
            mode   = int'($urandom_range(0, 19));
            drop_j = -1;
            rst_j  = -1;
            if (mode < 3) begin
                drop_j = int'($urandom_range(1, lat + 3));
            end else if (mode == 3) begin
                rst_j = int'($urandom_range(1, lat + 3));
            end
            run_txn(d, is_wr, both, $urandom, drop_j, rst_j, int'($urandom_range(0, 5)), rand256());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
Memory-side responder for the 4-beat, 64-bit burst protocol driven by the LLC cacheline adaptor.
- Holds a small line-organised memory array.
- Answers read and write requests after a programmable latency, with 4 consecutive response beats.
- Used as the synthesizable main-memory model behind the cache hierarchy in simulation and FPGA bring-up.

Parameters:
LATENCY, 4, cycles from request acceptance to first beat; legal range 1..15
LINE_IDX_W, 5, line-index width; array depth = 2**LINE_IDX_W lines of 256 bits
BURST_LEN, 4, beats per line; fixed at 4 (256/64), not overridable

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous, active-low reset
read_i  in  1  read request; held high by requester until transaction ends
write_i  in  1  write request; held high by requester until transaction ends
address_i  in  32  byte address; bits [4:0] ignored; line index = address_i[5+LINE_IDX_W-1:5]; higher bits ignored (aliasing)
burst_i  in  64  write beat data; beat k presented during the k-th resp_o cycle
burst_o  out  64  read beat data; valid only when resp_o=1 on a read, else 0
resp_o  out  1  beat strobe; high for exactly BURST_LEN consecutive cycles per completed transaction
err_o  out  1  one-cycle pulse: read_i and write_i both high when sampled in IDLE

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, beat counter=0, latency counter=0, resp_o=0, burst_o=0, err_o=0.
- Array contents are not cleared by reset and persist across reset.
- States: IDLE, LAT, BURST, DONE.
- IDLE: in the cycle T where read_i or write_i is first sampled high:
  - latch op and line index;
  - on a read, fetch the line into the line buffer;
  - next state = LAT if LATENCY>1, else BURST.
  - If both request inputs are high: read wins and err_o pulses in cycle T+1.
- LAT: counts LATENCY-1 cycles; then BURST. First resp_o is in cycle T+LATENCY exactly.
- BURST: resp_o=1 for beats k=0..3 in cycles T+LATENCY+k.
  - Read: burst_o = line_buf[64k +: 64].
  - Write: line_buf[64k +: 64] <= burst_i at each beat edge.
  - After beat 3: a write commits line_buf to the array in one cycle (at the beat-3 edge); next state = DONE.
- DONE: resp_o=0. Stay until read_i=0 and write_i=0, then IDLE.
  - A new request is accepted no earlier than the first IDLE cycle (minimum 1-cycle gap).
- Abort: read_i and write_i both low while in LAT or BURST causes return to IDLE next cycle.
  - resp_o drops immediately in that next cycle.
  - Write beats already captured are discarded; the array is unchanged.
- Address and op are latched at acceptance; address_i changes mid-transaction are ignored.
- Reset mid-transaction: all state cleared; a pending write is not committed.
- burst_o is forced to 0 whenever resp_o=0, and during write bursts.
- Beat counter is 2 bits and wraps 3->0 only on the BURST->DONE transition.
- Latency counter is 4 bits.

Decomposition:
- Package burst_mem_pkg:
  - state enum (IDLE, LAT, BURST, DONE);
  - constants BURST_W=64, LINE_W=256, BURST_LEN=4, OFFSET_BITS=5.
- Sub-module burst_mem_array: 2**LINE_IDX_W x 256 storage.
  - One combinational read port, one synchronous full-line write port (we, idx, wdata).
  - The FSM and line buffer stay in the top module.

Test Plan:
- Write then read: write line 0x0000_0040 with beats A0..A3 = 64'h1111…, 64'h2222…, 64'h3333…, 64'h4444…; read the same address -> 4 resp_o beats return identical data in order, starting T+4.
- Latency sweep: LATENCY=1 and LATENCY=15 -> first resp_o exactly at T+1 and T+15; resp_o high exactly 4 consecutive cycles; DONE holds until the request drops.
- Aliasing/offset: write at 0x0000_0020, read at 0x0000_003F and 0x8000_0020 (LINE_IDX_W=5) -> same data returned.
- Abort: drop write_i after beat 1 of a write to line 3 -> resp_o low next cycle; subsequent read of line 3 returns the prior contents.
- Conflict: read_i=write_i=1 in IDLE -> err_o pulses once at T+1; read burst proceeds; array unchanged.
- Reset mid-BURST: assert reset_n=0 during beat 2 of a write -> resp_o=0, burst_o=0 next cycle; line not modified; a new read completes normally after reset release.
